// File: rtl/bram_arb_pkg.sv
// Shared types and helpers for the BRAM round-robin arbiter.
package bram_arb_pkg;

  localparam int NUM_REQ_DEF   = 4;
  localparam int MAX_BURST_DEF = 4;
  // Widest requester count supported; onehot() is sized for it and callers truncate.
  localparam int REQ_MAX       = 8;

  localparam int REQ_IDX_W = $clog2(NUM_REQ_DEF);

  typedef logic [REQ_IDX_W-1:0]            req_idx_t;
  typedef logic [$clog2(MAX_BURST_DEF):0]  burst_cnt_t;

  // Decode a requester index into a one-hot vector.
  function automatic logic [REQ_MAX-1:0] onehot(input logic [2:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/bram_rr_arbiter_rr_pick.sv
// Rotating-priority picker: first set bit of req at or after start, wrapping.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   start,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   winner,
  output logic               any_valid
);

  int idx;

  // Walk the requesters cyclically from start; the first hit wins.
  always_comb begin
    grant     = '0;
    winner    = '0;
    any_valid = 1'b0;
    idx       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(start) + i) % NUM_REQ;
      if (!any_valid && req[idx]) begin
        any_valid  = 1'b1;
        grant[idx] = 1'b1;
        winner     = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/bram_rr_arbiter.sv
// Round-robin arbiter sharing one simple-dual-port BRAM between NUM_REQ
// requesters, with a bounded burst before priority rotates. One access per
// clock; read data returns one cycle after acceptance, tagged one-hot.
module bram_rr_arbiter
  import bram_arb_pkg::*;
#(
  parameter int NUM_REQ         = NUM_REQ_DEF,
  parameter int BRAM_ADDR_WIDTH = 6,
  parameter int BRAM_DATA_WIDTH = 256,
  parameter int MAX_BURST       = MAX_BURST_DEF
) (
  input  logic                                            clock,
  input  logic                                            reset_n,
  input  logic [NUM_REQ-1:0]                              req,
  input  logic [NUM_REQ-1:0]                              req_we,
  input  logic [NUM_REQ-1:0][BRAM_ADDR_WIDTH-1:0]         req_addr,
  input  logic [NUM_REQ-1:0][BRAM_DATA_WIDTH-1:0]         req_wdata,
  output logic [NUM_REQ-1:0]                              grant,
  output logic [NUM_REQ-1:0]                              rvalid,
  output logic [BRAM_DATA_WIDTH-1:0]                      rdata,
  output logic [BRAM_ADDR_WIDTH-1:0]                      bram_rd_addr,
  output logic [BRAM_ADDR_WIDTH-1:0]                      bram_wr_addr,
  output logic                                            bram_wr_en,
  output logic [BRAM_DATA_WIDTH-1:0]                      bram_din,
  input  logic [BRAM_DATA_WIDTH-1:0]                      bram_dout
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  localparam logic [IDX_W-1:0] LAST    = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

  logic [IDX_W-1:0]   owner, rd_owner, start, pick_idx, win;
  logic [CNT_W-1:0]   burst_cnt;
  logic               rd_pending;
  logic [NUM_REQ-1:0] owner_oh, pick_grant;
  logic               pick_any, lone, keep, accept;

  assign owner_oh = NUM_REQ'(onehot(3'(owner)));
  assign start    = (owner == LAST) ? '0 : owner + IDX_W'(1);
  // A lone owner is never preempted, so the burst limit only bites under contention.
  assign lone     = (req == owner_oh);
  assign keep     = (|(req & owner_oh)) && ((burst_cnt < CNT_MAX) || lone);

  // Search starts just past the owner so the owner is considered last.
  rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req       (req),
    .start     (start),
    .grant     (pick_grant),
    .winner    (pick_idx),
    .any_valid (pick_any)
  );

  // Keep rule overrides the rotating pick.
  always_comb begin
    grant  = pick_grant;
    win    = pick_idx;
    accept = pick_any;
    if (keep) begin
      grant  = owner_oh;
      win    = owner;
      accept = 1'b1;
    end
  end

  // Ownership and burst tracking; burst_cnt saturates for a lone holder.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      owner     <= LAST;
      burst_cnt <= '0;
    end else if (accept) begin
      owner <= win;
      if (win != owner)             burst_cnt <= '0;
      else if (burst_cnt != CNT_MAX) burst_cnt <= burst_cnt + CNT_W'(1);
    end
  end

  // BRAM command issue; write strobe and read-pending are single-cycle pulses.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bram_wr_en   <= 1'b0;
      bram_wr_addr <= '0;
      bram_rd_addr <= '0;
      bram_din     <= '0;
      rd_pending   <= 1'b0;
      rd_owner     <= '0;
    end else begin
      bram_wr_en <= 1'b0;
      rd_pending <= 1'b0;
      if (accept) begin
        if (req_we[win]) begin
          bram_wr_en   <= 1'b1;
          bram_wr_addr <= req_addr[win];
          bram_din     <= req_wdata[win];
        end else begin
          bram_rd_addr <= req_addr[win];
          rd_pending   <= 1'b1;
          rd_owner     <= win;
        end
      end
    end
  end

  // Read return: BRAM latched the address on the intervening negedge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rvalid <= '0;
      rdata  <= '0;
    end else begin
      rvalid <= rd_pending ? NUM_REQ'(onehot(3'(rd_owner))) : '0;
      if (rd_pending) rdata <= bram_dout;
    end
  end

endmodule

// File: tb/tb_bram_rr_arbiter.sv
// Bench for bram_rr_arbiter: behavioural BRAM, scoreboard model, directed vectors.
module tb_bram_rr_arbiter;

  localparam int N  = 4;
  localparam int AW = 6;
  localparam int DW = 256;
  localparam int MB = 4;

  logic                   clock = 1'b0;
  logic                   reset_n = 1'b0;
  logic [N-1:0]           req, req_we;
  logic [N-1:0][AW-1:0]   req_addr;
  logic [N-1:0][DW-1:0]   req_wdata;
  logic [N-1:0]           grant, rvalid;
  logic [DW-1:0]          rdata, bram_din, bram_dout;
  logic [AW-1:0]          bram_rd_addr, bram_wr_addr;
  logic                   bram_wr_en;

  logic [N-1:0]           grant1, rvalid1;
  logic [DW-1:0]          rdata1, bram_din1;
  logic [AW-1:0]          bram_rd_addr1, bram_wr_addr1;
  logic                   bram_wr_en1;
  logic [DW-1:0]          zero_dout = '0;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  bram_rr_arbiter #(.NUM_REQ(N), .BRAM_ADDR_WIDTH(AW), .BRAM_DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .grant(grant), .rvalid(rvalid), .rdata(rdata),
    .bram_rd_addr(bram_rd_addr), .bram_wr_addr(bram_wr_addr), .bram_wr_en(bram_wr_en),
    .bram_din(bram_din), .bram_dout(bram_dout));

  // Pure round-robin variant for the wrap-around case.
  bram_rr_arbiter #(.NUM_REQ(N), .BRAM_ADDR_WIDTH(AW), .BRAM_DATA_WIDTH(DW), .MAX_BURST(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .grant(grant1), .rvalid(rvalid1), .rdata(rdata1),
    .bram_rd_addr(bram_rd_addr1), .bram_wr_addr(bram_wr_addr1), .bram_wr_en(bram_wr_en1),
    .bram_din(bram_din1), .bram_dout(zero_dout));

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req     = '0;
    @(negedge clock);
    @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  // Behavioural BRAM: write and read-address latch on negedge.
  logic [DW-1:0] mem [64];
  logic [AW-1:0] rd_lat;
  assign bram_dout = mem[rd_lat];
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = {8{32'hC0DE0000 | i}};
    rd_lat = '0;
    forever begin
      @(negedge clock);
      if (bram_wr_en) mem[bram_wr_addr] = bram_din;
      rd_lat = bram_rd_addr;
    end
  end

  // Scoreboard: tracks owner and run length, predicts grant, write strobe and read returns.
  initial begin : model
    logic [DW-1:0] m_mem [64];
    int            m_owner, m_run, w, idx;
    logic [N-1:0]  mg, rv_s1, rv_s2;
    logic [DW-1:0] rd_s1, rd_s2, din_e;
    logic [AW-1:0] wa_e;
    logic          we_e;
    for (int i = 0; i < 64; i++) m_mem[i] = {8{32'hC0DE0000 | i}};
    m_owner = N - 1; m_run = 1;
    rv_s1 = '0; rv_s2 = '0; rd_s1 = '0; rd_s2 = '0; we_e = 1'b0; wa_e = '0; din_e = '0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        m_owner = N - 1; m_run = 1;
        rv_s1 = '0; rv_s2 = '0; we_e = 1'b0;
        chk("m_rst_rvalid", DW'(rvalid), '0);
        chk("m_rst_wr_en", DW'(bram_wr_en), '0);
      end else begin
        chk("m_rvalid", DW'(rvalid), DW'(rv_s2));
        if (rv_s2 != '0) chk("m_rdata", rdata, rd_s2);
        chk("m_wr_en", DW'(bram_wr_en), DW'(we_e));
        if (we_e) begin
          chk("m_wr_addr", DW'(bram_wr_addr), DW'(wa_e));
          chk("m_din", bram_din, din_e);
        end
        rv_s2 = rv_s1; rd_s2 = rd_s1; rv_s1 = '0; we_e = 1'b0;
        w = -1;
        if (req[m_owner] && (m_run < MB || $countones(req) == 1)) w = m_owner;
        else
          for (int k = 1; k <= N; k++) begin
            idx = (m_owner + k) % N;
            if (w < 0 && req[idx]) w = idx;
          end
        mg = (w < 0) ? '0 : N'(1 << w);
        chk("m_grant", DW'(grant), DW'(mg));
        if (w >= 0) begin
          if (req_we[w]) begin
            m_mem[req_addr[w]] = req_wdata[w];
            we_e = 1'b1; wa_e = req_addr[w]; din_e = req_wdata[w];
          end else begin
            rv_s1 = mg; rd_s1 = m_mem[req_addr[w]];
          end
          m_run   = (w == m_owner) ? m_run + 1 : 1;
          m_owner = w;
        end
      end
    end
  end

  logic [N-1:0] bseq [10] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010,
                              4'b0010, 4'b0010, 4'b0010, 4'b0001, 4'b0001};
  logic [N-1:0] wseq [6]  = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};

  // Directed stimulus with literal expectations.
  initial begin : stim
    int pulses;
    req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    reset_n = 1'b0;

    @(negedge clock);
    chk("rst_grant",   DW'(grant), '0);
    chk("rst_rvalid",  DW'(rvalid), '0);
    chk("rst_wr_en",   DW'(bram_wr_en), '0);
    chk("rst_rdata",   rdata, '0);
    chk("rst_rd_addr", DW'(bram_rd_addr), '0);
    chk("rst_wr_addr", DW'(bram_wr_addr), '0);
    chk("rst_din",     bram_din, '0);
    @(posedge clock);
    #1 reset_n = 1'b1;

    // Single read of addr 5.
    req = 4'b0001; req_we = '0; req_addr[0] = 6'd5;
    @(negedge clock); chk("rd_grant", DW'(grant), DW'(4'b0001));
    tick(); req = '0;
    @(negedge clock);
    chk("rd_addr", DW'(bram_rd_addr), DW'(6'd5));
    chk("rd_early", DW'(rvalid), '0);
    tick();
    @(negedge clock);
    chk("rd_rvalid", DW'(rvalid), DW'(4'b0001));
    chk("rd_rdata", rdata, {8{32'hC0DE0005}});
    tick();

    // Write addr 3 then read it back next cycle.
    req = 4'b0001; req_we = 4'b0001; req_addr[0] = 6'd3; req_wdata[0] = {8{32'hBEEF0003}};
    @(negedge clock); chk("raw_wgrant", DW'(grant), DW'(4'b0001));
    tick(); req_we = '0;
    @(negedge clock);
    chk("raw_wr_en", DW'(bram_wr_en), DW'(1'b1));
    chk("raw_wr_addr", DW'(bram_wr_addr), DW'(6'd3));
    chk("raw_din", bram_din, {8{32'hBEEF0003}});
    chk("raw_rgrant", DW'(grant), DW'(4'b0001));
    tick(); req = '0;
    @(negedge clock); chk("raw_early", DW'(rvalid), '0);
    tick();
    @(negedge clock);
    chk("raw_rvalid", DW'(rvalid), DW'(4'b0001));
    chk("raw_rdata", rdata, {8{32'hBEEF0003}});
    tick();

    // Burst limit with two contenders.
    do_reset();
    req = 4'b0011; req_we = '0; req_addr[0] = 6'd1; req_addr[1] = 6'd2;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock); chk($sformatf("burst_grant%0d", i), DW'(grant), DW'(bseq[i]));
      tick();
    end
    req = '0; repeat (3) tick();

    // Lone requester keeps the BRAM indefinitely.
    do_reset();
    pulses = 0;
    req = 4'b0100; req_we = '0; req_addr[2] = 6'd7;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock); chk($sformatf("lone_grant%0d", i), DW'(grant), DW'(4'b0100));
      if (rvalid == 4'b0100) pulses++;
      tick();
    end
    req = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      if (rvalid == 4'b0100) pulses++;
      tick();
    end
    chk("lone_pulses", DW'(pulses), DW'(10));

    // Wrap-around on the MAX_BURST=1 instance.
    do_reset();
    req = 4'b1011; req_we = '0; req_addr[3] = 6'd8;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock); chk($sformatf("wrap_grant%0d", i), DW'(grant1), DW'(wseq[i]));
      tick();
    end
    req = '0; repeat (3) tick();

    // Reset lands between a read accept and its return.
    req = 4'b0010; req_we = '0; req_addr[1] = 6'd9; req_addr[2] = 6'd10;
    @(negedge clock); chk("mid_grant", DW'(grant), DW'(4'b0010));
    @(posedge clock);
    #2 reset_n = 1'b0; req = 4'b0110;
    @(negedge clock);
    chk("mid_rvalid", DW'(rvalid), '0);
    chk("mid_wr_en", DW'(bram_wr_en), '0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    chk("post_grant", DW'(grant), DW'(4'b0010));
    chk("post_rvalid", DW'(rvalid), '0);
    tick(); req = '0;
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
